// File: rtl/core_pkg.sv
// Shared types and constants for the core sequencing controller.
package core_pkg;

  localparam int IMEM_DEPTH_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HALT,
    ST_RUN,
    ST_STEP
  } seq_state_t;

endpackage

// File: rtl/core_seq_cnt.sv
// Free-running 32-bit cycle counter with synchronous clear and enable; wraps naturally.
module core_seq_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= 32'd0;
    else if (clr)
      cnt <= 32'd0;
    else if (en)
      cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Core sequencer: program load into instruction memory, then halt/run/step control.
// Optional breakpoint logic is compiled in with `define CORE_SEQ_BKPT_EN.
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_rst,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [31:0]       pc,
  input  logic [31:0]       bkpt_addr,
  output logic              core_reset,
  output logic              core_en,
  output logic              halted,
  output logic              load_ovf,
  output logic              bkpt_hit,
  output logic [31:0]       cycle_cnt
);

  seq_state_t        state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic              handshake;
  logic              ptr_at_end;
  logic              load_ovf_set;
  logic              bkpt_match;

  assign ld_ready   = (state == ST_IDLE) || (state == ST_LOAD);
  assign handshake  = ld_valid & ld_ready;
  assign ptr_at_end = (ptr == ADDR_W'(IMEM_DEPTH - 1));
  assign imem_we    = handshake;
  assign imem_waddr = ptr;
  assign imem_wdata = ld_data;

`ifdef CORE_SEQ_BKPT_EN
  // The first RUN cycle after HALT skips the compare so a resume at the breakpoint executes it.
  logic run_first;
  logic bkpt_hit_q;

  assign bkpt_match = (state == ST_RUN) && !run_first && (pc == bkpt_addr);
  assign bkpt_hit   = bkpt_hit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_first  <= 1'b0;
      bkpt_hit_q <= 1'b0;
    end else begin
      run_first <= (state == ST_HALT);
      if (soft_rst)
        bkpt_hit_q <= 1'b0;
      else if (bkpt_match)
        bkpt_hit_q <= 1'b1;
      else if ((state == ST_HALT) && (state_next == ST_RUN))
        bkpt_hit_q <= 1'b0;
    end
  end
`else
  logic unused_bkpt;
  assign unused_bkpt = ^{pc, bkpt_addr};
  assign bkpt_match  = 1'b0;
  assign bkpt_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    load_ovf_set = 1'b0;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (handshake) begin
          if (ld_last) begin
            state_next = ST_HALT;
          end else if (ptr_at_end) begin
            state_next   = ST_HALT;
            load_ovf_set = 1'b1;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      ST_HALT: begin
        if (halt_req)
          state_next = ST_HALT;
        else if (run_req)
          state_next = ST_RUN;
        else if (step_req)
          state_next = ST_STEP;
      end
      ST_RUN: begin
        if (halt_req || bkpt_match)
          state_next = ST_HALT;
      end
      ST_STEP: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
    if (soft_rst)
      state_next = ST_IDLE;
  end

  assign core_reset = (state == ST_IDLE) || (state == ST_LOAD);
  assign core_en    = ((state == ST_RUN) && !bkpt_match) || (state == ST_STEP);
  assign halted     = (state == ST_HALT);

  // Pointer saturates at the last word; the overflow path leaves LOAD so it is never reused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      load_ovf <= 1'b0;
    end else if (soft_rst) begin
      ptr      <= '0;
      load_ovf <= 1'b0;
    end else begin
      if (handshake && !ptr_at_end)
        ptr <= ptr + ADDR_W'(1);
      if (load_ovf_set)
        load_ovf <= 1'b1;
    end
  end

  core_seq_cnt u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (core_en),
    .clr   (soft_rst),
    .cnt   (cycle_cnt)
  );

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed self-checking bench for core_seq_ctrl; breakpoint checks run when CORE_SEQ_BKPT_EN is defined.
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, soft_rst;
  logic        ld_valid, ld_last, ld_ready;
  logic [31:0] ld_data;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        run_req, halt_req, step_req;
  logic [31:0] pc, bkpt_addr;
  logic        core_reset, core_en, halted, load_ovf, bkpt_hit;
  logic [31:0] cycle_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt;

  always #5 clk = ~clk;

  core_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .soft_rst   (soft_rst),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .pc         (pc),
    .bkpt_addr  (bkpt_addr),
    .core_reset (core_reset),
    .core_en    (core_en),
    .halted     (halted),
    .load_ovf   (load_ovf),
    .bkpt_hit   (bkpt_hit),
    .cycle_cnt  (cycle_cnt)
  );

  // Counts instruction-memory writes actually committed on a clock edge.
  always @(posedge clk or posedge reset) begin
    if (reset)
      wr_cnt <= 0;
    else if (imem_we)
      wr_cnt <= wr_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic last);
    @(negedge clk);
    ld_valid = valid;
    ld_data  = data;
    ld_last  = last;
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ld_ready"},   32'(ld_ready),   32'd1);
    checkOutput({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    checkOutput({tag, "_core_en"},    32'(core_en),    32'd0);
    checkOutput({tag, "_halted"},     32'(halted),     32'd0);
    checkOutput({tag, "_load_ovf"},   32'(load_ovf),   32'd0);
    checkOutput({tag, "_bkpt_hit"},   32'(bkpt_hit),   32'd0);
    checkOutput({tag, "_cycle_cnt"},  cycle_cnt,       32'd0);
  endtask

  initial begin
    reset = 1'b1; soft_rst = 1'b0;
    ld_valid = 1'b0; ld_data = 32'd0; ld_last = 1'b0;
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    pc = 32'd0; bkpt_addr = 32'h8;
    repeat (2) @(negedge clk);
    #1;
    checkResetState("rst");
    checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Three-word program, last flagged on the third word
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h11 * (i + 1), (i == 2));
      checkOutput($sformatf("ld3_we%0d", i),    32'(imem_we),    32'd1);
      checkOutput($sformatf("ld3_addr%0d", i),  32'(imem_waddr), i);
      checkOutput($sformatf("ld3_data%0d", i),  imem_wdata,      32'h11 * (i + 1));
      checkOutput($sformatf("ld3_creset%0d", i), 32'(core_reset), 32'd1);
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("ld3_core_reset", 32'(core_reset), 32'd0);
    checkOutput("ld3_halted",     32'(halted),     32'd1);
    checkOutput("ld3_ld_ready",   32'(ld_ready),   32'd0);
    checkOutput("ld3_wr_cnt",     wr_cnt,          32'd3);

    // Single step
    @(negedge clk); step_req = 1'b1; #1;
    checkOutput("step_pre_en", 32'(core_en), 32'd0);
    @(negedge clk); step_req = 1'b0; #1;
    checkOutput("step_en", 32'(core_en), 32'd1);
    @(negedge clk); #1;
    checkOutput("step_post_en",  32'(core_en), 32'd0);
    checkOutput("step_halted",   32'(halted),  32'd1);
    checkOutput("step_cnt",      cycle_cnt,    32'd1);

    // run+halt together stays halted; then a 10-cycle run
    @(negedge clk); run_req = 1'b1; halt_req = 1'b1; step_req = 1'b1;
    @(negedge clk); halt_req = 1'b0; step_req = 1'b0; #1;
    checkOutput("prio_halted", 32'(halted),  32'd1);
    checkOutput("prio_en",     32'(core_en), 32'd0);
    @(negedge clk); run_req = 1'b0; #1;
    checkOutput("run_en", 32'(core_en), 32'd1);
    step_req = 1'b1;
    repeat (9) @(negedge clk);
    step_req = 1'b0; halt_req = 1'b1; #1;
    checkOutput("run_still_en", 32'(core_en), 32'd1);
    @(negedge clk); halt_req = 1'b0; #1;
    checkOutput("run_halted", 32'(halted),  32'd1);
    checkOutput("run_en_off", 32'(core_en), 32'd0);
    checkOutput("run_cnt",    cycle_cnt,    32'd11);

`ifdef CORE_SEQ_BKPT_EN
    @(negedge clk); run_req = 1'b1; pc = 32'h0;
    @(negedge clk); run_req = 1'b0; #1;
    checkOutput("bk_en_pc0", 32'(core_en), 32'd1);
    @(negedge clk); pc = 32'h4; #1;
    checkOutput("bk_en_pc4", 32'(core_en), 32'd1);
    @(negedge clk); pc = 32'h8; #1;
    checkOutput("bk_en_pc8", 32'(core_en), 32'd0);
    @(negedge clk); #1;
    checkOutput("bk_halted", 32'(halted),   32'd1);
    checkOutput("bk_hit",    32'(bkpt_hit), 32'd1);
    @(negedge clk); run_req = 1'b1;
    @(negedge clk); run_req = 1'b0; #1;
    checkOutput("bk_resume_en",  32'(core_en),  32'd1);
    checkOutput("bk_hit_clear",  32'(bkpt_hit), 32'd0);
    @(negedge clk); pc = 32'hC; halt_req = 1'b1; #1;
    checkOutput("bk_past_en", 32'(core_en), 32'd1);
    @(negedge clk); halt_req = 1'b0; #1;
    checkOutput("bk_rehalt", 32'(halted), 32'd1);
`else
    checkOutput("nobk_hit", 32'(bkpt_hit), 32'd0);
`endif

    // Soft reset from HALT
    @(negedge clk); soft_rst = 1'b1;
    @(negedge clk); soft_rst = 1'b0; #1;
    checkResetState("srst");

    // Reload one word, run exactly five counted cycles, then async reset
    applyStimulus(1'b1, 32'h55, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("rl_halted", 32'(halted), 32'd1);
    @(negedge clk); run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("mid_run_cnt", cycle_cnt, 32'd5);
    checkOutput("mid_run_en",  32'(core_en), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkResetState("arst");
    @(negedge clk); reset = 1'b0;

    // 64 words without last: overflow on the final slot
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 32'hA000_0000 + i, 1'b0);
      checkOutput($sformatf("ovf_addr%0d", i), 32'(imem_waddr), i);
    end
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
    checkOutput("ovf_we",       32'(imem_we),  32'd0);
    checkOutput("ovf_ld_ready", 32'(ld_ready), 32'd0);
    checkOutput("ovf_flag",     32'(load_ovf), 32'd1);
    checkOutput("ovf_halted",   32'(halted),   32'd1);
    checkOutput("ovf_wr_cnt",   wr_cnt,        32'd64);
    applyStimulus(1'b0, 32'd0, 1'b0);
    soft_rst = 1'b1;
    @(negedge clk); soft_rst = 1'b0; #1;
    checkOutput("ovf_clear", 32'(load_ovf), 32'd0);
    checkOutput("ovf_idle",  32'(ld_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
CORE_SEQ_CTRL -- requirements
Module: core_seq_ctrl

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64, instruction-memory depth in words.
REQ-002 SHALL have parameter ADDR_W, default 6, width of imem_waddr; must equal log2(IMEM_DEPTH).
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port soft_rst  in  1  synchronous return to IDLE.
REQ-006 SHALL have ports ld_valid in 1, ld_data in 32, ld_last in 1, ld_ready out 1  program-load stream.
REQ-007 SHALL have ports imem_we out 1, imem_waddr out ADDR_W, imem_wdata out 32  instruction-memory write port.
REQ-008 SHALL have ports run_req in 1, halt_req in 1, step_req in 1  execution commands, level-sampled each cycle.
REQ-009 SHALL have ports pc in 32 (core PC) and bkpt_addr in 32 (breakpoint address).
REQ-010 SHALL have ports core_reset out 1 (holds core in reset) and core_en out 1 (core PC/register/data-memory update enable).
REQ-011 SHALL have status outputs: halted 1, load_ovf 1, bkpt_hit 1, cycle_cnt 32.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, HALT, RUN, STEP.
REQ-013 SHALL assert ld_ready in IDLE and LOAD only; handshake = ld_valid & ld_ready.
REQ-014 SHALL drive imem_we = handshake combinationally, with imem_waddr = load pointer and imem_wdata = ld_data; pointer increments after each handshake.
REQ-015 IDLE: handshake -> LOAD; handshake with ld_last -> HALT; run/halt/step ignored.
REQ-016 LOAD: handshake with ld_last -> HALT; handshake at pointer IMEM_DEPTH-1 without ld_last -> HALT, load_ovf set (sticky).
REQ-017 core_reset SHALL be 1 in IDLE and LOAD, 0 in HALT, RUN, STEP.
REQ-018 core_en SHALL be 1 in RUN and STEP, 0 otherwise; halted = 1 in HALT only.
REQ-019 HALT: halt_req -> stay; else run_req -> RUN; else step_req -> STEP; priority halt > run > step.
REQ-020 STEP: exactly one cycle with core_en=1, then HALT unconditionally.
REQ-021 RUN: halt_req -> HALT; core_en is 0 from the first cycle in HALT; run/step in RUN ignored.
REQ-022 soft_rst SHALL override all transitions: next state IDLE; clears pointer, load_ovf, bkpt_hit, cycle_cnt.
REQ-023 cycle_cnt SHALL increment by 1 each cycle core_en=1, wrapping 0xFFFFFFFF -> 0.
REQ-024 Pointer SHALL never exceed IMEM_DEPTH-1; no writes occur outside IDLE/LOAD.

Reset
REQ-025 reset SHALL force state IDLE, pointer 0, core_reset 1, core_en 0, ld_ready 1, halted 0, load_ovf 0, bkpt_hit 0, cycle_cnt 0.
REQ-026 reset asserted mid-LOAD or mid-RUN SHALL abort immediately; partially loaded words are not invalidated.

Configuration
REQ-027 Macro CORE_SEQ_BKPT_EN SHALL compile in breakpoint logic.
REQ-028 With CORE_SEQ_BKPT_EN: in RUN, pc == bkpt_addr SHALL force core_en=0 combinationally that cycle, next state HALT, bkpt_hit=1 (sticky until soft_rst/reset or next run_req).
REQ-029 With CORE_SEQ_BKPT_EN: compare SHALL be masked in the first RUN cycle after HALT, so resuming at the breakpoint executes it; STEP never compares.
REQ-030 Without CORE_SEQ_BKPT_EN: bkpt_addr ignored, bkpt_hit tied 0, ports retained.

Structure
REQ-031 Shared package core_pkg SHALL hold the FSM state typedef and IMEM_DEPTH default constant.
REQ-032 Cycle counter SHALL be a sub-module core_seq_cnt (enable, clear, 32-bit wrap); everything else is flat.

Verification
REQ-033 Load 3 words 0x11,0x22,0x33, last on third -> imem writes at addr 0,1,2; state HALT; core_reset falls the cycle after the third write.
REQ-034 Load 64 words, ld_last never set -> 64 writes, load_ovf=1, HALT, ld_ready=0, 65th word not written.
REQ-035 HALT, step_req 1 cycle -> core_en high exactly 1 cycle, cycle_cnt=1, back in HALT.
REQ-036 HALT, run_req+halt_req together -> stays HALT; then run_req alone, 10 cycles, halt_req -> cycle_cnt=10 +/-0, core_en low in HALT.
REQ-037 CORE_SEQ_BKPT_EN, bkpt_addr=0x8, pc reaches 0x8 in RUN -> core_en=0 that cycle, HALT, bkpt_hit=1; run_req -> core proceeds past 0x8.
REQ-038 reset asserted mid-RUN with cycle_cnt=0x5 -> all outputs at REQ-025 values asynchronously; soft_rst in HALT -> IDLE, cycle_cnt=0.
